// File: rtl/logic_block_cluster_if.sv
// Configuration chain and LUT I/O bundle of one logic block cluster.
// The slave side is the cluster itself; the master side is the tile or a bench.
interface logic_block_cluster_if #(
    parameter int K = 2,
    parameter int N = 1
);
    logic           cfg_en;
    logic           cfg_in;
    logic           cfg_out;
    logic           cfg_done;
    logic           cfg_err;
    logic           ce;
    logic [N*K-1:0] in;
    logic [N-1:0]   out;

    modport master (
        output cfg_en, cfg_in, ce, in,
        input  cfg_out, cfg_done, cfg_err, out
    );

    modport slave (
        input  cfg_en, cfg_in, ce, in,
        output cfg_out, cfg_done, cfg_err, out
    );
endinterface

// File: rtl/logic_block_cluster.sv
// Cluster of N K-input LUTs with optional output flops, configured over a serial chain.
// Define LB_FF_INIT_EN to add a per-LUT init bit that seeds each flop on activation.
module logic_block_cluster #(
    parameter int K = 2,
    parameter int N = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_block_cluster_if.slave  bus
);
    localparam int TT = 2 ** K;
`ifdef LB_FF_INIT_EN
    localparam int W = TT + 2;
`else
    localparam int W = TT + 1;
`endif
    localparam int TOTAL = N * W;
    localparam int CW    = $clog2(TOTAL + 2);

    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        LOADING = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [TOTAL-1:0] cfg_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [N-1:0]     ff_q;
    logic [N-1:0]     ff_d;
    logic             done_q;
    logic             err_q;
    logic [N-1:0]     lut;
    logic [N-1:0]     sync;
    logic [N-1:0]     init;
    logic             activate;

    for (genvar g = 0; g < N; g++) begin : g_lut
        logic [W-1:0]  slice;
        logic [TT-1:0] mem;
        assign slice   = cfg_q[g*W +: W];
        assign mem     = slice[TT-1:0];
        assign lut[g]  = mem[bus.in[g*K +: K]];
        assign sync[g] = slice[TT];
`ifdef LB_FF_INIT_EN
        assign init[g] = slice[TT+1];
`else
        assign init[g] = 1'b0;
`endif
    end

    // A load is accepted only when exactly TOTAL bits were shifted before cfg_en fell.
    assign activate = (state_q == LOADING) && !bus.cfg_en && (count_q == CW'(TOTAL));

    always_comb begin
        count_d = count_q;
        if (bus.cfg_en) begin
            if (state_q != LOADING)
                count_d = CW'(1);
            else if (count_q != CW'(TOTAL + 1))
                count_d = count_q + CW'(1);
        end
    end

    always_comb begin
        ff_d = '0;
        if (state_q == ACTIVE)
            ff_d = bus.ce ? lut : ff_q;
        else if (activate)
            ff_d = init;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; the config chain is reset too, since it is a shift register
    // rather than a RAM and must come up in a known, deactivated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '0;
            count_q <= '0;
            ff_q    <= '0;
        end else begin
            if (bus.cfg_en)
                cfg_q <= {bus.cfg_in, cfg_q[TOTAL-1:1]};
            count_q <= count_d;
            ff_q    <= ff_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNCONF;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                UNCONF, ACTIVE: begin
                    if (bus.cfg_en) begin
                        state_q <= LOADING;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                LOADING: begin
                    if (!bus.cfg_en) begin
                        if (activate) begin
                            state_q <= ACTIVE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= UNCONF;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= UNCONF;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = (state_q == ACTIVE) ? ((sync & ff_q) | (~sync & lut)) : '0;
    assign bus.cfg_out  = cfg_q[0];
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_logic_block_cluster.sv
// Directed bench for logic_block_cluster: a K=2,N=1 cluster and a K=3,N=2 cluster.
module tb_logic_block_cluster;
`ifdef LB_FF_INIT_EN
    localparam int W2 = 10;
`else
    localparam int W2 = 9;
`endif
    localparam int TOTAL2 = 2 * W2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic_block_cluster_if #(.K(2), .N(1)) if1 ();
    logic_block_cluster_if #(.K(3), .N(2)) if2 ();

    logic_block_cluster #(.K(2), .N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    logic_block_cluster #(.K(3), .N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit j of bits is the j-th bit shifted; cfg_en drops afterwards for one edge.
    task automatic load1(input logic [7:0] bits, input int n);
        for (int j = 0; j < n; j++) begin
            if1.cfg_en = 1'b1;
            if1.cfg_in = bits[j];
            tick();
        end
        if1.cfg_en = 1'b0;
        tick();
    endtask

    logic [4:0]        xor_t;
    logic [4:0]        xor_s;
    logic [4:0]        and_t;
    logic [TOTAL2-1:0] v2;
    logic [1:0]        exp_out2;

    initial begin
        checks = 0;
        errors = 0;
        xor_t  = 5'b00110;
        xor_s  = 5'b10110;
        and_t  = 5'b01000;
        rst_n  = 1'b0;
        if1.cfg_en = 1'b0; if1.cfg_in = 1'b0; if1.ce = 1'b0; if1.in = '0;
        if2.cfg_en = 1'b0; if2.cfg_in = 1'b0; if2.ce = 1'b0; if2.in = '0;
        #12;
        check("rst_done", if1.cfg_done, 0);
        check("rst_err", if1.cfg_err, 0);
        check("rst_out", if1.out, 0);
        check("rst_cfg_out", if1.cfg_out, 0);
        rst_n = 1'b1;
        tick();

        // XOR, combinational output
        load1({3'b000, xor_t}, 5);
        check("xor_done", if1.cfg_done, 1);
        check("xor_err", if1.cfg_err, 0);
        for (int v = 0; v < 4; v++) begin
            if1.in = 2'(v);
            #1;
            check("xor_comb_out", if1.out, {31'b0, ^2'(v)});
        end

        // XOR, registered output
        load1({3'b000, xor_s}, 5);
        if1.ce = 1'b1;
        if1.in = 2'b01;
        #1;
        check("sync_pre_edge", if1.out, 0);
        tick();
        check("sync_post_edge", if1.out, 1);
        if1.ce = 1'b0;
        if1.in = 2'b11;
        #1;
        check("sync_ce0_comb", if1.out, 1);
        tick();
        check("sync_ce0_hold", if1.out, 1);

        // Short load, then a correct one
        load1({3'b000, xor_t}, 4);
        check("short_err", if1.cfg_err, 1);
        check("short_done", if1.cfg_done, 0);
        for (int v = 0; v < 4; v++) begin
            if1.in = 2'(v);
            #1;
            check("short_out", if1.out, 0);
        end
        load1({3'b000, xor_t}, 5);
        check("recover_err", if1.cfg_err, 0);
        check("recover_done", if1.cfg_done, 1);
        if1.in = 2'b01;
        #1;
        check("recover_out", if1.out, 1);

        // Reload AND table while ACTIVE; old XOR bits stream out of cfg_out
        if1.in = 2'b11;
        for (int j = 0; j < 5; j++) begin
            check("reload_cfg_out", if1.cfg_out, {31'b0, xor_t[j]});
            if1.cfg_en = 1'b1;
            if1.cfg_in = and_t[j];
            tick();
            check("reload_out", if1.out, 0);
            check("reload_done", if1.cfg_done, 0);
        end
        if1.cfg_en = 1'b0;
        tick();
        check("and_done", if1.cfg_done, 1);
        check("and_out_11", if1.out, 1);
        if1.in = 2'b10;
        #1;
        check("and_out_10", if1.out, 0);

        // Over-length load
        if1.in = 2'b11;
        load1({3'b000, and_t}, 6);
        check("over_err", if1.cfg_err, 1);
        check("over_done", if1.cfg_done, 0);
        check("over_out", if1.out, 0);

        // cfg_en held high never activates
        if1.cfg_en = 1'b1;
        if1.cfg_in = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        check("held_err_cleared", if1.cfg_err, 0);
        check("held_done", if1.cfg_done, 0);
        if1.cfg_en = 1'b0;
        tick();
        check("held_err", if1.cfg_err, 1);
        check("held_out", if1.out, 0);

        // Reset mid-load
        for (int j = 0; j < 3; j++) begin
            if1.cfg_en = 1'b1;
            if1.cfg_in = and_t[j];
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", if1.out, 0);
        check("midrst_done", if1.cfg_done, 0);
        check("midrst_err", if1.cfg_err, 0);
        if1.cfg_en = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        load1({3'b000, and_t}, 5);
        check("postrst_done", if1.cfg_done, 1);
        check("postrst_out", if1.out, 1);

        // Asynchronous reset while ACTIVE clears the output at once
        #2;
        rst_n = 1'b0;
        #1;
        check("actrst_out", if1.out, 0);
        check("actrst_done", if1.cfg_done, 0);
        #1;
        rst_n = 1'b1;
        tick();

        // K=3, N=2: LUT0 majority, LUT1 all-zero table with sync=1 and init=1
        v2 = '0;
        v2[7:0]  = 8'hE8;
        v2[W2+8] = 1'b1;
`ifdef LB_FF_INIT_EN
        v2[W2+9] = 1'b1;
        exp_out2 = 2'b11;
`else
        exp_out2 = 2'b01;
`endif
        if2.ce = 1'b0;
        if2.in = 6'b000_011;
        for (int j = 0; j < TOTAL2; j++) begin
            if2.cfg_en = 1'b1;
            if2.cfg_in = v2[j];
            tick();
        end
        if2.cfg_en = 1'b0;
        tick();
        check("c2_done", if2.cfg_done, 1);
        check("c2_err", if2.cfg_err, 0);
        check("c2_out_act", if2.out, {30'b0, exp_out2});
        if2.in = 6'b000_001;
        #1;
        check("c2_maj_001", if2.out, {30'b0, 1'b0, exp_out2[1]});
        if2.in = 6'b000_110;
        if2.ce = 1'b1;
        tick();
        check("c2_ce_capture", if2.out, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
